mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max consecutive mem_ready-low cycles tolerated in a memory wait state (>=2).
REQ-002 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 opcode  input  6  instruction opcode field, valid from instruction register during DECODE.
REQ-006 mem_ready  input  1  memory handshake; high = current access completes this cycle.
REQ-007 ctrl  output  18  datapath controls, Moore-decoded from state (bit map REQ-011).
REQ-008 state  output  4  current FSM state encoding (REQ-012).
REQ-009 trap  output  1  sticky fault flag.
REQ-010 retired  output  CNT_W  count of completed instructions.

Function
REQ-011 ctrl bits SHALL be: [0]PCWrite [1]PCWriteCond [2]BranchNe [3]IorD [4]MemRead [5]MemWrite [6]IRWrite [7]MemtoReg(1=ALU,0=memory) [8]RegDst [9]RegWrite [10]ALUSrcA [12:11]ALUSrcB [14:13]ALUOp [16:15]PCSource [17]ExtendSel(1=sign,0=zero); any bit not listed for a state SHALL be 0.
REQ-012 States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 JUMP=9 ORIEX=10 ORIWB=11 TRAP=12.
REQ-013 FETCH: MemRead, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCWrite asserted only when mem_ready=1; stay while mem_ready=0, else DECODE.
REQ-014 DECODE: ALUSrcB=11, ALUOp=00, ExtendSel=1; latch opcode into op_q; next by opcode: 0->EXEC, 35/43->MEMADR, 4/5->BRANCH, 2->JUMP, 13->ORIEX, other->TRAP.
REQ-015 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtendSel=1; next MEMRD if op_q=35, MEMWR if 43.
REQ-016 MEMRD: MemRead, IorD; hold until mem_ready=1, then MEMWB. MEMWB: RegWrite, MemtoReg=0, RegDst=0; next FETCH.
REQ-017 MEMWR: MemWrite, IorD; hold until mem_ready=1, then FETCH.
REQ-018 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB: RegDst, MemtoReg, RegWrite -> FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond, PCSource=01, BranchNe=(op_q==5) -> FETCH. JUMP: PCWrite, PCSource=10 -> FETCH.
REQ-020 ORIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11, ExtendSel=0 -> ORIWB: MemtoReg, RegWrite, RegDst=0 -> FETCH.
REQ-021 Latency with mem_ready constantly 1: R/SW/ORI 4 cycles, LW 5, BEQ/BNE/J 3; each mem_ready-low cycle adds one.
REQ-022 Wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR and on mem_ready=1, increment per mem_ready-low cycle there, saturating at MEM_TIMEOUT.
REQ-023 retired SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ORIWB; wraps modulo 2^CNT_W; never increments from TRAP or reset.
REQ-024 TRAP: ctrl=0, trap=1, state held until reset regardless of inputs.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force state=FETCH, op_q=0, wait counter=0, retired=0, trap=0, mid-instruction included; ctrl then shows FETCH decoding.
REQ-026 rst_n=0 SHALL take priority over every transition, including TRAP exit and mem_ready.

Configuration
REQ-027 Macro MCTRL_EXC_EN defined: illegal opcode in DECODE, or wait counter reaching MEM_TIMEOUT with mem_ready=0, SHALL go to TRAP.
REQ-028 MCTRL_EXC_EN undefined: TRAP unreachable, trap tied 0; illegal opcode DECODE->FETCH without retiring; wait states hold indefinitely.

Verification
REQ-029 Reset, then opcode=0, mem_ready=1 -> states 0,1,6,7,0; RegWrite/RegDst/MemtoReg=1 in ALUWB; retired=1.
REQ-030 opcode=35, mem_ready low 3 cycles in MEMRD -> LW takes 8 cycles; MEMWB shows RegWrite=1, MemtoReg=0.
REQ-031 opcode=5 -> BRANCH cycle ctrl shows PCWriteCond=1, BranchNe=1, PCSource=01; opcode=4 same with BranchNe=0.
REQ-032 With MCTRL_EXC_EN, opcode=63 -> state 12, trap=1, held 20 cycles; rst_n=0 one edge -> state 0, trap=0, retired=0.
REQ-033 With MCTRL_EXC_EN, MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP after 4 wait cycles; without macro, stays FETCH.
REQ-034 CNT_W=4, 16 consecutive J instructions -> retired wraps to 0; rst_n=0 during MEMWR -> no write retired, state 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with memory wait handling and retired-instruction counter.
// Define MCTRL_EXC_EN to trap on illegal opcodes and on memory wait timeouts.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic [17:0]      ctrl,
  output logic [3:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int b_pcwrite = 0;
  localparam int b_pcwritecond = 1;
  localparam int b_branchne = 2;
  localparam int b_iord = 3;
  localparam int b_memread = 4;
  localparam int b_memwrite = 5;
  localparam int b_irwrite = 6;
  localparam int b_memtoreg = 7;
  localparam int b_regdst = 8;
  localparam int b_regwrite = 9;
  localparam int b_alusrca = 10;
  localparam int b_alusrcb = 11;
  localparam int b_aluop = 13;
  localparam int b_pcsource = 15;
  localparam int b_extendsel = 17;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    ORIEX = 4'd10, ORIWB = 4'd11, TRAP = 4'd12
  } state_t;
  state_t st, nxt;
  logic [5:0] op_q;
  logic [WW-1:0] wcnt, wcnt_d;
  logic wait_st, retire;
  assign wait_st = st inside {FETCH, MEMRD, MEMWR};
  assign state = st;
`ifdef MCTRL_EXC_EN
  logic timeout;
  assign timeout = wait_st && !mem_ready && wcnt == WW'(MEM_TIMEOUT);
  assign trap = st == TRAP;
`else
  assign trap = 1'b0;
`endif
  always_comb begin
    nxt = st;
    case (st)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE:
        case (opcode)
          6'd0:         nxt = EXEC;
          6'd35, 6'd43: nxt = MEMADR;
          6'd4, 6'd5:   nxt = BRANCH;
          6'd2:         nxt = JUMP;
          6'd13:        nxt = ORIEX;
`ifdef MCTRL_EXC_EN
          default:      nxt = TRAP;
`else
          default:      nxt = FETCH;
`endif
        endcase
      MEMADR: nxt = op_q == 6'd35 ? MEMRD : MEMWR;
      MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
      EXEC:   nxt = ALUWB;
      ORIEX:  nxt = ORIWB;
      TRAP:   nxt = TRAP;
      default: nxt = FETCH;
    endcase
`ifdef MCTRL_EXC_EN
    if (timeout) nxt = TRAP;
`endif
  end
  assign retire = nxt == FETCH && st inside {MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ORIWB};
  // Counter survives only while stalling in the same wait state; any entry or completion clears it.
  assign wcnt_d = (wait_st && !mem_ready && nxt == st) ?
                  (wcnt == WW'(MEM_TIMEOUT) ? wcnt : wcnt + WW'(1)) : '0;
  always_comb begin
    ctrl = '0;
    case (st)
      FETCH: begin
        ctrl[b_memread] = 1'b1;
        ctrl[b_alusrcb +: 2] = 2'b01;
        ctrl[b_irwrite] = mem_ready;
        ctrl[b_pcwrite] = mem_ready;
      end
      DECODE: begin
        ctrl[b_alusrcb +: 2] = 2'b11;
        ctrl[b_extendsel] = 1'b1;
      end
      MEMADR: begin
        ctrl[b_alusrca] = 1'b1;
        ctrl[b_alusrcb +: 2] = 2'b10;
        ctrl[b_extendsel] = 1'b1;
      end
      MEMRD: begin
        ctrl[b_memread] = 1'b1;
        ctrl[b_iord] = 1'b1;
      end
      MEMWB: ctrl[b_regwrite] = 1'b1;
      MEMWR: begin
        ctrl[b_memwrite] = 1'b1;
        ctrl[b_iord] = 1'b1;
      end
      EXEC: begin
        ctrl[b_alusrca] = 1'b1;
        ctrl[b_aluop +: 2] = 2'b10;
      end
      ALUWB: begin
        ctrl[b_regdst] = 1'b1;
        ctrl[b_memtoreg] = 1'b1;
        ctrl[b_regwrite] = 1'b1;
      end
      BRANCH: begin
        ctrl[b_alusrca] = 1'b1;
        ctrl[b_aluop +: 2] = 2'b01;
        ctrl[b_pcwritecond] = 1'b1;
        ctrl[b_pcsource +: 2] = 2'b01;
        ctrl[b_branchne] = op_q == 6'd5;
      end
      JUMP: begin
        ctrl[b_pcwrite] = 1'b1;
        ctrl[b_pcsource +: 2] = 2'b10;
      end
      ORIEX: begin
        ctrl[b_alusrca] = 1'b1;
        ctrl[b_alusrcb +: 2] = 2'b10;
        ctrl[b_aluop +: 2] = 2'b11;
      end
      ORIWB: begin
        ctrl[b_memtoreg] = 1'b1;
        ctrl[b_regwrite] = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= FETCH;
      op_q <= '0;
      wcnt <= '0;
      retired <= '0;
    end else begin
      st <= nxt;
      wcnt <= wcnt_d;
      if (st == DECODE) op_q <= opcode;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: instruction-path model plus directed programs for mips_multicycle_ctrl.
module tb_mips_multicycle_ctrl;
  localparam int MT = 4;
  logic clk = 0, rst_n = 0, mem_ready = 1, trap;
  logic [5:0] opcode = 0;
  logic [17:0] ctrl;
  logic [3:0] state, retired;
  int n_chk = 0, n_fail = 0, cyc;
  bit chk_en = 0;
  mips_multicycle_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .ctrl(ctrl), .state(state), .trap(trap), .retired(retired));
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Control words written out from the bit map, one per state.
  function automatic logic [17:0] exp_ctrl(input int s, input logic mr, input int op);
    case (s)
      0: return mr ? 18'h00851 : 18'h00810;
      1: return 18'h21800;
      2: return 18'h21400;
      3: return 18'h00018;
      4: return 18'h00200;
      5: return 18'h00028;
      6: return 18'h04400;
      7: return 18'h00380;
      8: return op == 5 ? 18'h0A406 : 18'h0A402;
      9: return 18'h10001;
      10: return 18'h07400;
      11: return 18'h00280;
      default: return 18'h0;
    endcase
  endfunction
  // Model: each instruction is a path of states after DECODE; wait states repeat while memory is busy.
  int m_state = 0, m_op = 0, m_wait = 0, m_ret = 0;
  bit m_trap = 0;
  int q[$];
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", 32'(state), 32'(m_state));
      check("ctrl", 32'(ctrl), 32'(exp_ctrl(m_state, mem_ready, m_op)));
      check("trap", 32'(trap), 32'(m_trap));
      check("retired", 32'(retired), 32'(m_ret));
    end
    if (!rst_n) begin
      m_state = 0; m_op = 0; m_wait = 0; m_ret = 0; m_trap = 0; q.delete();
    end else if (!m_trap) begin
      if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
`ifdef MCTRL_EXC_EN
        if (m_wait == MT) begin m_trap = 1; m_state = 12; end
`endif
        if (m_wait < MT) m_wait++;
      end else begin
        m_wait = 0;
        if (m_state == 1) begin
          m_op = int'(opcode);
          case (m_op)
            0: q = '{6, 7};
            35: q = '{2, 3, 4};
            43: q = '{2, 5};
            4, 5: q = '{8};
            2: q = '{9};
            13: q = '{10, 11};
            default: q.delete();
          endcase
`ifdef MCTRL_EXC_EN
          if (q.size() == 0) begin m_trap = 1; m_state = 12; end
`endif
        end
        if (!m_trap) begin
          if (m_state == 0) m_state = 1;
          else if (q.size() > 0) m_state = q.pop_front();
          else begin
            if (m_state != 1) m_ret = (m_ret + 1) % 16;
            m_state = 0;
          end
        end
      end
    end
  end
  task automatic step(input logic mr);
    mem_ready = mr;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    step(0);
    rst_n = 1;
  endtask
  task automatic instr(input logic [5:0] op, input int fw, input int mw, output int c_out);
    bit left = 0;
    c_out = -1;
    opcode = op;
    for (int c = 1; c <= 60; c++) begin
      bit hold;
      hold = (m_state == 0 && fw > 0) || ((m_state == 3 || m_state == 5) && mw > 0);
      if (hold) begin
        if (m_state == 0) fw--;
        else mw--;
      end
      step(!hold);
      if (m_state != 0) left = 1;
      else if (left) begin
        c_out = c;
        break;
      end
    end
    if (c_out < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL instr_bound: op %0d got no return to FETCH within 60 cycles, required return", op);
    end
  endtask
  task automatic branch_chk(input logic [5:0] op, input logic [17:0] exp);
    opcode = op;
    step(1);
    step(1);
    check("branch_state", 32'(state), 32'd8);
    check("branch_ctrl", 32'(ctrl), 32'(exp));
    step(1);
    check("branch_done", 32'(state), 32'd0);
  endtask
  initial begin
    rst_n = 0;
    step(1);
    step(1);
    rst_n = 1;
    chk_en = 1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctrl", 32'(ctrl), 32'h00851);
    check("reset_retired", 32'(retired), 32'd0);
    instr(6'd0, 0, 0, cyc);
    check("r_latency", 32'(cyc), 32'd4);
    check("r_retired", 32'(retired), 32'd1);
    instr(6'd35, 0, 3, cyc);
    check("lw_latency", 32'(cyc), 32'd8);
    instr(6'd43, 1, 2, cyc);
    check("sw_latency", 32'(cyc), 32'd7);
    branch_chk(6'd5, 18'h0A406);
    branch_chk(6'd4, 18'h0A402);
    instr(6'd2, 0, 0, cyc);
    check("j_latency", 32'(cyc), 32'd3);
    instr(6'd13, 0, 0, cyc);
    check("ori_latency", 32'(cyc), 32'd4);
    check("seq_retired", 32'(retired), 32'd7);
`ifdef MCTRL_EXC_EN
    opcode = 6'd63;
    step(1);
    step(1);
    check("illegal_trap_state", 32'(state), 32'd12);
    for (int i = 0; i < 20; i++) begin
      opcode = 6'($urandom);
      step(1'($urandom));
    end
    check("trap_held_state", 32'(state), 32'd12);
    check("trap_held_flag", 32'(trap), 32'd1);
    do_reset();
    check("trap_exit_state", 32'(state), 32'd0);
    check("trap_exit_flag", 32'(trap), 32'd0);
    check("trap_exit_retired", 32'(retired), 32'd0);
`else
    instr(6'd63, 0, 0, cyc);
    check("illegal_latency", 32'(cyc), 32'd2);
    check("illegal_retired", 32'(retired), 32'd7);
`endif
    opcode = 6'd0;
    repeat (6) step(0);
`ifdef MCTRL_EXC_EN
    check("fetch_timeout", 32'(state), 32'd12);
`else
    check("fetch_timeout", 32'(state), 32'd0);
`endif
    do_reset();
    check("reset_prio_state", 32'(state), 32'd0);
    check("reset_prio_trap", 32'(trap), 32'd0);
    for (int i = 0; i < 15; i++) instr(6'd2, 0, 0, cyc);
    check("j15_retired", 32'(retired), 32'd15);
    instr(6'd2, 0, 0, cyc);
    check("j16_wrap", 32'(retired), 32'd0);
    instr(6'd0, 0, 0, cyc);
    opcode = 6'd43;
    step(1);
    step(1);
    step(0);
    step(0);
    check("memwr_state", 32'(state), 32'd5);
    check("memwr_retired", 32'(retired), 32'd1);
    rst_n = 0;
    step(1);
    rst_n = 1;
    check("memwr_reset_state", 32'(state), 32'd0);
    check("memwr_reset_retired", 32'(retired), 32'd0);
    step(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
